// File: rtl/pe_word_serial_if.sv
// Word-stream bundle for the MWR2MM word-serial processing element.
// The master drives operand words; the slave returns result words.
interface pe_word_serial_if #(
    parameter int W = 3
);
    logic         in_valid;
    logic         in_first;
    logic         in_last;
    logic         xi;
    logic [W-1:0] y_word;
    logic [W-1:0] m_word;
    logic [W-1:0] s_word;

    logic         out_valid;
    logic         out_first;
    logic         out_last;
    logic [W-1:0] s_out;
    logic [W-1:0] y_out;
    logic [W-1:0] m_out;
    logic         ovf;
    logic         done;
    logic         err;

    modport master (
        output in_valid, in_first, in_last, xi,
        output y_word, m_word, s_word,
        input  out_valid, out_first, out_last,
        input  s_out, y_out, m_out, ovf, done, err
    );

    modport slave (
        input  in_valid, in_first, in_last, xi,
        input  y_word, m_word, s_word,
        output out_valid, out_first, out_last,
        output s_out, y_out, m_out, ovf, done, err
    );
endinterface

// File: rtl/pe_word_serial.sv
// Radix-2 MWR2MM word-serial PE: S' = (S + xi*Y + q*M) / 2, one W-bit word per cycle.
// Optional PE_STALL_EN lets in_valid gaps freeze the pass between operand words.
module pe_word_serial #(
    parameter int W = 3
) (
    input logic             clk,
    input logic             rst_n,
    pe_word_serial_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_nx;
    logic         x_r;
    logic         q_r;
    logic [1:0]   c_r;
    logic [W-1:0] prev;
    logic [W-1:0] y_d1;
    logic [W-1:0] m_d1;
    logic         first_pend;

    logic         start;
    logic         step;
    logic         flush;
    logic         err_c;
    logic         q0;
    logic [W+1:0] t0;
    logic [W+1:0] tj;

    always_comb begin
        start = bus.in_valid & bus.in_first;
        flush = (state == FLUSH);
`ifdef PE_STALL_EN
        step  = (state == RUN) & bus.in_valid & ~bus.in_first;
        err_c = ((state == RUN) & start)
              | ((state != RUN) & bus.in_valid & ~bus.in_first);
`else
        // Without stalls the pass free-runs: a missing valid is flagged, not waited on.
        step  = (state == RUN) & ~start;
        err_c = ((state == RUN) & start)
              | ((state == RUN) & ~bus.in_valid)
              | ((state != RUN) & bus.in_valid & ~bus.in_first);
`endif
    end

    always_comb begin
        q0 = (bus.xi & bus.y_word[0]) ^ bus.s_word[0];
        t0 = {2'b00, bus.s_word};
        if (bus.xi) t0 = t0 + {2'b00, bus.y_word};
        if (q0)     t0 = t0 + {2'b00, bus.m_word};
        tj = {{W{1'b0}}, c_r} + {2'b00, bus.s_word};
        if (x_r)    tj = tj + {2'b00, bus.y_word};
        if (q_r)    tj = tj + {2'b00, bus.m_word};
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            start:               state_nx = bus.in_last ? FLUSH : RUN;
            step & bus.in_last:  state_nx = FLUSH;
            flush & ~start:      state_nx = IDLE;
            default:             state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            x_r           <= 1'b0;
            q_r           <= 1'b0;
            c_r           <= 2'b00;
            prev          <= '0;
            y_d1          <= '0;
            m_d1          <= '0;
            first_pend    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.s_out     <= '0;
            bus.y_out     <= '0;
            bus.m_out     <= '0;
            bus.ovf       <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.err       <= err_c;
            bus.out_valid <= 1'b0;
            bus.out_first <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.done      <= 1'b0;
            if (flush) begin
                bus.s_out     <= {c_r[0], prev[W-1:1]};
                bus.ovf       <= c_r[1];
                bus.out_valid <= 1'b1;
                bus.out_first <= first_pend;
                bus.out_last  <= 1'b1;
                bus.done      <= 1'b1;
                bus.y_out     <= y_d1;
                bus.m_out     <= m_d1;
                first_pend    <= 1'b0;
            end else if (step) begin
                // Word j's LSB completes the shifted output word j-1.
                bus.s_out     <= {tj[0], prev[W-1:1]};
                bus.out_valid <= 1'b1;
                bus.out_first <= first_pend;
                bus.y_out     <= y_d1;
                bus.m_out     <= m_d1;
                first_pend    <= 1'b0;
                prev          <= tj[W-1:0];
                c_r           <= tj[W+1:W];
                y_d1          <= bus.y_word;
                m_d1          <= bus.m_word;
            end
            if (start) begin
                x_r        <= bus.xi;
                q_r        <= q0;
                c_r        <= t0[W+1:W];
                prev       <= t0[W-1:0];
                y_d1       <= bus.y_word;
                m_d1       <= bus.m_word;
                first_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_word_serial.sv
// Directed-vector bench for pe_word_serial at W=3.
module tb_pe_word_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    pe_word_serial_if #(.W(3)) bus ();

    pe_word_serial #(.W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic f, input logic l,
                         input logic x, input logic [2:0] y,
                         input logic [2:0] m, input logic [2:0] s);
        bus.in_valid = v;
        bus.in_first = f;
        bus.in_last  = l;
        bus.xi       = x;
        bus.y_word   = y;
        bus.m_word   = m;
        bus.s_word   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic test_reset();
        idle();
        idle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.s_out !== 3'b000) begin errors++; $display("FAIL rst_s: got %b want 000", bus.s_out); end
        checks++; if ({bus.done, bus.err, bus.ovf} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {bus.done, bus.err, bus.ovf}); end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_t1();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t1_bubble: got %b want 0", bus.out_valid); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.out_valid, bus.out_first, bus.s_out} !== 5'b11100) begin errors++; $display("FAIL t1_w0: got %b want 11100", {bus.out_valid, bus.out_first, bus.s_out}); end
        checks++; if ({bus.y_out, bus.m_out} !== 6'b011101) begin errors++; $display("FAIL t1_ym0: got %b want 011101", {bus.y_out, bus.m_out}); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t1_early_done: got %b want 0", bus.done); end
        idle();
        checks++; if ({bus.out_valid, bus.out_last, bus.done, bus.ovf, bus.s_out} !== 7'b1110000) begin errors++; $display("FAIL t1_w1: got %b want 1110000", {bus.out_valid, bus.out_last, bus.done, bus.ovf, bus.s_out}); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t1_err: got %b want 0", bus.err); end
        idle();
        checks++; if ({bus.out_valid, bus.done} !== 2'b00) begin errors++; $display("FAIL t1_after: got %b want 00", {bus.out_valid, bus.done}); end
    endtask

    task automatic test_t2();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 3'b101, 3'b110);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.out_valid, bus.out_first, bus.s_out} !== 5'b11011) begin errors++; $display("FAIL t2_w0: got %b want 11011", {bus.out_valid, bus.out_first, bus.s_out}); end
        idle();
        checks++; if ({bus.out_valid, bus.done, bus.ovf, bus.s_out} !== 6'b110000) begin errors++; $display("FAIL t2_w1: got %b want 110000", {bus.out_valid, bus.done, bus.ovf, bus.s_out}); end
        idle();
    endtask

    task automatic test_single_word();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 3'b111, 3'b110);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL t3_bubble: got %b want 0", bus.out_valid); end
        idle();
        checks++; if ({bus.out_valid, bus.out_first, bus.out_last, bus.done, bus.ovf} !== 5'b11111) begin errors++; $display("FAIL t3_flags: got %b want 11111", {bus.out_valid, bus.out_first, bus.out_last, bus.done, bus.ovf}); end
        checks++; if ({bus.s_out, bus.y_out} !== 6'b010111) begin errors++; $display("FAIL t3_s: got %b want 010111", {bus.s_out, bus.y_out}); end
        idle();
        checks++; if ({bus.done, bus.ovf} !== 2'b00) begin errors++; $display("FAIL t3_clear: got %b want 00", {bus.done, bus.ovf}); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.out_valid, bus.out_first, bus.s_out, bus.y_out} !== 8'b11100011) begin errors++; $display("FAIL t4_o0: got %b want 11100011", {bus.out_valid, bus.out_first, bus.s_out, bus.y_out}); end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 3'b101, 3'b110);
        checks++; if ({bus.out_valid, bus.out_last, bus.done, bus.s_out, bus.y_out} !== 9'b111000000) begin errors++; $display("FAIL t4_o1: got %b want 111000000", {bus.out_valid, bus.out_last, bus.done, bus.s_out, bus.y_out}); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.out_valid, bus.out_first, bus.done, bus.s_out, bus.y_out} !== 9'b110011110) begin errors++; $display("FAIL t4_o2: got %b want 110011110", {bus.out_valid, bus.out_first, bus.done, bus.s_out, bus.y_out}); end
        idle();
        checks++; if ({bus.out_valid, bus.out_last, bus.done, bus.s_out, bus.m_out} !== 9'b111000000) begin errors++; $display("FAIL t4_o3: got %b want 111000000", {bus.out_valid, bus.out_last, bus.done, bus.s_out, bus.m_out}); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL t4_err: got %b want 0", bus.err); end
        idle();
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.out_valid, bus.out_first, bus.s_out, bus.y_out, bus.m_out} !== 11'd0) begin errors++; $display("FAIL t5_clear: got %b want 0", {bus.out_valid, bus.out_first, bus.s_out, bus.y_out, bus.m_out}); end
        @(posedge clk);
        #1;
        checks++; if ({bus.done, bus.out_last} !== 2'b00) begin errors++; $display("FAIL t5_nodone: got %b want 00", {bus.done, bus.out_last}); end
        rst_n = 1'b1;
        idle();
        checks++; if ({bus.done, bus.out_valid} !== 2'b00) begin errors++; $display("FAIL t5_nodone2: got %b want 00", {bus.done, bus.out_valid}); end
        test_t2();
    endtask

    task automatic test_restart();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 3'b101, 3'b110);
        checks++; if ({bus.err, bus.out_valid, bus.done} !== 3'b100) begin errors++; $display("FAIL t6_abort: got %b want 100", {bus.err, bus.out_valid, bus.done}); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.err, bus.out_valid, bus.out_first, bus.s_out} !== 6'b011011) begin errors++; $display("FAIL t6_w0: got %b want 011011", {bus.err, bus.out_valid, bus.out_first, bus.s_out}); end
        idle();
        checks++; if ({bus.out_valid, bus.done, bus.s_out} !== 5'b11000) begin errors++; $display("FAIL t6_w1: got %b want 11000", {bus.out_valid, bus.done, bus.s_out}); end
        idle();
    endtask

    task automatic test_idle_err();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111, 3'b111);
        checks++; if ({bus.err, bus.out_valid} !== 2'b10) begin errors++; $display("FAIL idle_err: got %b want 10", {bus.err, bus.out_valid}); end
        idle();
        checks++; if ({bus.err, bus.out_valid} !== 2'b00) begin errors++; $display("FAIL idle_drop: got %b want 00", {bus.err, bus.out_valid}); end
    endtask

`ifdef PE_STALL_EN
    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 3'b111);
            checks++; if ({bus.out_valid, bus.err} !== 2'b00) begin errors++; $display("FAIL stall_gap%0d: got %b want 00", i, {bus.out_valid, bus.err}); end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.out_valid, bus.out_first, bus.s_out, bus.y_out} !== 8'b11100011) begin errors++; $display("FAIL stall_w0: got %b want 11100011", {bus.out_valid, bus.out_first, bus.s_out, bus.y_out}); end
        idle();
        checks++; if ({bus.out_valid, bus.done, bus.s_out} !== 5'b11000) begin errors++; $display("FAIL stall_w1: got %b want 11000", {bus.out_valid, bus.done, bus.s_out}); end
        idle();
    endtask
`else
    task automatic test_free_run();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 3'b101, 3'b000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000);
        checks++; if ({bus.err, bus.out_valid, bus.s_out} !== 5'b11100) begin errors++; $display("FAIL free_w0: got %b want 11100", {bus.err, bus.out_valid, bus.s_out}); end
        idle();
        checks++; if ({bus.err, bus.done, bus.s_out} !== 5'b01000) begin errors++; $display("FAIL free_w1: got %b want 01000", {bus.err, bus.done, bus.s_out}); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_t1();
        test_t2();
        test_single_word();
        test_back_to_back();
        test_mid_reset();
        test_restart();
        test_idle_err();
`ifdef PE_STALL_EN
        test_stall();
`else
        test_free_run();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
